// File: rtl/sr_regfile_sb.sv
// sr_regfile_sb
// Parametrised register file with prioritised forwarding, same-cycle write
// bypass and a per-register scoreboard for long-latency writers.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   rd_addr/rd_data       NRD packed read ports (combinational, 0-cycle)
//   rd_busy               per port: operand not yet available, consumer stalls
//   fwd_vld/addr/data     NFWD forwarding sources; index 0 = youngest, highest priority
//   wr_en/addr/data       writeback port
//   wr_sb_clr             writeback retires a scoreboarded op (clears busy)
//   sb_set/sb_set_addr    issue of a long-latency op (marks busy)
//   sb_flush              clears every busy bit
//   dbg_addr/dbg_data     raw array read, no bypass
//   pend_cnt              registered count of busy registers
//   sb_err                sticky scoreboard protocol error
//
// Qualifier semantics: fwd_data[j] is only looked at when fwd_vld[j]=1 and
// wr_data only when wr_en=1; the data buses may carry anything (including X)
// otherwise. There is no back-pressure: every qualified input is consumed in
// the cycle it is presented.
module sr_regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 2,
  localparam int AW  = $clog2(NREG),
  localparam int CW  = $clog2(NREG + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NFWD-1:0]      fwd_vld,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  input  logic                 wr_sb_clr,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_flush,
  input  logic [AW-1:0]        dbg_addr,
  output logic [XLEN-1:0]      dbg_data,
  output logic [CW-1:0]        pend_cnt,
  output logic                 sb_err
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   pend_q, pend_d;
  logic            err_q, err_d;

  logic wr_vld;
  logic clr_vld;
  logic set_vld;

  assign wr_vld  = wr_en && (wr_addr != '0);
  assign clr_vld = wr_vld && wr_sb_clr;
  assign set_vld = sb_set && (sb_set_addr != '0);

  // ---------------------------------------------------------------- read ports
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rd_addr[gi*AW +: AW];

    // Lowest priority first; later assignments override, so the forwarding
    // loop runs from the oldest source down to index 0 (youngest wins).
    always_comb begin
      d = mem_q[a];
      b = busy_q[a];
      if (wr_en && (wr_addr == a)) begin
        d = wr_data;
        b = busy_q[a] && !wr_sb_clr;
      end
      for (int j = NFWD - 1; j >= 0; j--) begin
        if (fwd_vld[j] && (fwd_addr[j*AW +: AW] == a)) begin
          d = fwd_data[j*XLEN +: XLEN];
          b = 1'b0;
        end
      end
      if (a == '0) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[gi*XLEN +: XLEN] = d;
    assign rd_busy[gi]              = b;
  end

  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];
  assign pend_cnt = pend_q;
  assign sb_err   = err_q;

  // ---------------------------------------------------------------- scoreboard
  always_comb begin
    busy_d = busy_q;
    if (sb_flush) busy_d = '0;
    if (clr_vld)  busy_d[wr_addr] = 1'b0;
    // Set is applied last so a new issue survives both flush and clear.
    if (set_vld)  busy_d[sb_set_addr] = 1'b1;
    busy_d[0] = 1'b0;

    pend_d = '0;
    for (int k = 0; k < NREG; k++) pend_d = pend_d + CW'(busy_d[k]);

    // Errors look at the pre-update state and ignore flush.
    err_d = err_q;
    if (set_vld && busy_q[sb_set_addr] && !(clr_vld && (wr_addr == sb_set_addr)))
      err_d = 1'b1;
    if (clr_vld && !busy_q[wr_addr])
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // ---------------------------------------------------------------- array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) mem_q[k] <= '0;
    end else if (wr_vld) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_sr_regfile_sb.sv
module tb_sr_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NFWD = 2;
  localparam int AW   = $clog2(NREG);
  localparam int CW   = $clog2(NREG + 1);

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NFWD-1:0]      fwd_vld;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 wr_sb_clr;
  logic                 sb_set;
  logic [AW-1:0]        sb_set_addr;
  logic                 sb_flush;
  logic [AW-1:0]        dbg_addr;
  logic [XLEN-1:0]      dbg_data;
  logic [CW-1:0]        pend_cnt;
  logic                 sb_err;

  sr_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .fwd_vld(fwd_vld), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_sb_clr(wr_sb_clr),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .pend_cnt(pend_cnt), .sb_err(sb_err)
  );

  int vecs  = 0;
  int fails = 0;

  // ---------------------------------------------------------- reference model
  logic [XLEN-1:0] m_mem  [NREG];
  bit              m_busy [NREG];
  bit              m_err;

  function automatic int m_pend();
    int n = 0;
    for (int r = 1; r < NREG; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  // First-match read rule: forward (lowest index) > writeback > array.
  function automatic logic [XLEN:0] exp_rd(input int p);
    int a = int'(rd_addr[p*AW +: AW]);
    if (a == 0) return '0;
    for (int j = 0; j < NFWD; j++)
      if (fwd_vld[j] && int'(fwd_addr[j*AW +: AW]) == a)
        return {1'b0, fwd_data[j*XLEN +: XLEN]};
    if (wr_en && int'(wr_addr) == a)
      return {m_busy[a] && !wr_sb_clr, wr_data};
    return {m_busy[a], m_mem[a]};
  endfunction

  function automatic logic [XLEN-1:0] exp_dbg();
    return (dbg_addr == '0) ? '0 : m_mem[dbg_addr];
  endfunction

  function automatic logic [XLEN-1:0] port_data(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    m_err = 0;
  endtask

  // ---------------------------------------------------------- driver tasks
  // Advance one clock edge, updating the model with the inputs presented now.
  task automatic step();
    bit nb [NREG];
    bit clr = wr_en && wr_sb_clr && wr_addr != 0;
    bit set = sb_set && sb_set_addr != 0;
    if (set && m_busy[sb_set_addr] && !(clr && wr_addr == sb_set_addr)) m_err = 1;
    if (clr && !m_busy[wr_addr]) m_err = 1;
    nb = m_busy;
    if (sb_flush) for (int r = 0; r < NREG; r++) nb[r] = 0;
    if (clr) nb[wr_addr] = 0;
    if (set) nb[sb_set_addr] = 1;
    if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
    m_busy = nb;
    @(posedge clk);
    #1;
  endtask

  // Quiescent inputs; data buses carry junk to show it is ignored.
  task automatic idle();
    fwd_vld = '0; fwd_addr = '0;
    fwd_data = {$urandom(), $urandom()};
    wr_en = 0; wr_addr = '0; wr_data = $urandom(); wr_sb_clr = 0;
    sb_set = 0; sb_set_addr = '0; sb_flush = 0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_fwd(input int j, input bit v, input int a, input logic [XLEN-1:0] d);
    fwd_vld[j] = v;
    fwd_addr[j*AW +: AW] = AW'(a);
    fwd_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic write(input int a, input logic [XLEN-1:0] d, input bit clr);
    wr_en = 1; wr_addr = AW'(a); wr_data = d; wr_sb_clr = clr;
  endtask

  task automatic sbset(input int a);
    sb_set = 1; sb_set_addr = AW'(a);
  endtask

  // ---------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1; idle(); rd_addr = '0; dbg_addr = '0;
    model_reset();
    set_rd(0, 5); set_rd(1, 17); dbg_addr = 5'd9;
    #2;
    if (rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    vecs++;
    if (rd_busy !== '0) begin fails++; $display("FAIL reset_rd_busy: got %b expected 0", rd_busy); end
    vecs++;
    if (pend_cnt !== '0 || sb_err !== 1'b0 || dbg_data !== '0) begin
      fails++; $display("FAIL reset_state: pend=%0d err=%b dbg=%h expected 0/0/0", pend_cnt, sb_err, dbg_data);
    end
    vecs++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_write_bypass();
    idle(); write(3, 32'hDEADBEEF, 0); set_rd(0, 3); #1;
    if (port_data(0) !== 32'hDEADBEEF || rd_busy[0] !== 1'b0) begin
      fails++; $display("FAIL wb_bypass: got %h/%b expected deadbeef/0", port_data(0), rd_busy[0]);
    end
    vecs++;
    step(); idle(); dbg_addr = 5'd3; #1;
    if (port_data(0) !== 32'hDEADBEEF) begin
      fails++; $display("FAIL wb_array: got %h expected deadbeef", port_data(0));
    end
    vecs++;
    if (dbg_data !== 32'hDEADBEEF) begin
      fails++; $display("FAIL dbg_read: got %h expected deadbeef", dbg_data);
    end
    vecs++;
    write(0, 32'h55, 0); set_rd(1, 0); #1;
    if (port_data(1) !== '0) begin fails++; $display("FAIL r0_bypass: got %h expected 0", port_data(1)); end
    vecs++;
    step(); idle(); dbg_addr = '0; #1;
    if (port_data(1) !== '0 || dbg_data !== '0) begin
      fails++; $display("FAIL r0_array: got %h dbg %h expected 0/0", port_data(1), dbg_data);
    end
    vecs++;
  endtask

  task automatic test_fwd_priority();
    idle(); write(7, 32'h10, 0); step(); idle();
    set_rd(0, 7);
    set_fwd(0, 1, 7, 32'h30); set_fwd(1, 1, 7, 32'h20); #1;
    if (port_data(0) !== 32'h30) begin fails++; $display("FAIL fwd_both: got %h expected 30", port_data(0)); end
    vecs++;
    fwd_vld = 2'b10; #1;
    if (port_data(0) !== 32'h20) begin fails++; $display("FAIL fwd_one: got %h expected 20", port_data(0)); end
    vecs++;
    fwd_vld = 2'b00; #1;
    if (port_data(0) !== 32'h10) begin fails++; $display("FAIL fwd_none: got %h expected 10", port_data(0)); end
    vecs++;
    set_fwd(0, 1, 0, 32'h99); set_rd(1, 0); #1;
    if (port_data(1) !== '0) begin fails++; $display("FAIL fwd_r0: got %h expected 0", port_data(1)); end
    vecs++;
    idle();
  endtask

  task automatic test_load_use();
    idle(); sbset(9); step(); idle(); set_rd(0, 9); #1;
    if (rd_busy[0] !== 1'b1 || pend_cnt !== CW'(1)) begin
      fails++; $display("FAIL lu_busy: got busy=%b pend=%0d expected 1/1", rd_busy[0], pend_cnt);
    end
    vecs++;
    write(9, 32'hABCD, 1); #1;
    if (rd_busy[0] !== 1'b0 || port_data(0) !== 32'hABCD) begin
      fails++; $display("FAIL lu_retire: got busy=%b data=%h expected 0/abcd", rd_busy[0], port_data(0));
    end
    vecs++;
    step(); idle(); #1;
    if (rd_busy[0] !== 1'b0 || pend_cnt !== '0 || port_data(0) !== 32'hABCD || sb_err !== 1'b0) begin
      fails++; $display("FAIL lu_after: busy=%b pend=%0d data=%h err=%b expected 0/0/abcd/0",
                        rd_busy[0], pend_cnt, port_data(0), sb_err);
    end
    vecs++;
  endtask

  task automatic test_collision();
    idle(); sbset(4); step();
    idle(); write(4, 32'h4444, 1); sbset(4); step();
    idle(); set_rd(0, 4); #1;
    if (rd_busy[0] !== 1'b1 || pend_cnt !== CW'(1) || sb_err !== 1'b0) begin
      fails++; $display("FAIL coll_set_wins: busy=%b pend=%0d err=%b expected 1/1/0", rd_busy[0], pend_cnt, sb_err);
    end
    vecs++;
    sbset(4); step(); idle(); #1;
    if (sb_err !== 1'b1) begin fails++; $display("FAIL coll_err: got %b expected 1", sb_err); end
    vecs++;
    step(); step(); #1;
    if (sb_err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b expected 1", sb_err); end
    vecs++;
  endtask

  task automatic test_reset_midrun();
    idle(); write(5, 32'h1234, 0); sbset(5); step();
    idle(); set_rd(0, 5); #1;
    if (rd_busy[0] !== 1'b1 || port_data(0) !== 32'h1234) begin
      fails++; $display("FAIL pre_rst: busy=%b data=%h expected 1/1234", rd_busy[0], port_data(0));
    end
    vecs++;
    rst = 1; model_reset(); #1;
    if (port_data(0) !== '0 || rd_busy[0] !== 1'b0 || pend_cnt !== '0 || sb_err !== 1'b0) begin
      fails++; $display("FAIL midrun_rst: data=%h busy=%b pend=%0d err=%b expected 0/0/0/0",
                        port_data(0), rd_busy[0], pend_cnt, sb_err);
    end
    vecs++;
    @(posedge clk); #1; rst = 0; #1;
    if (port_data(0) !== '0 || rd_busy[0] !== 1'b0) begin
      fails++; $display("FAIL post_rst: data=%h busy=%b expected 0/0", port_data(0), rd_busy[0]);
    end
    vecs++;
  endtask

  task automatic test_flush();
    idle(); sbset(2); step(); sbset(6); step(); sbset(8); step(); idle(); #1;
    if (pend_cnt !== CW'(3)) begin fails++; $display("FAIL flush_pre: pend=%0d expected 3", pend_cnt); end
    vecs++;
    sb_flush = 1; sbset(6); step(); idle();
    set_rd(0, 2); set_rd(1, 8); #1;
    if (pend_cnt !== CW'(1) || rd_busy !== 2'b00) begin
      fails++; $display("FAIL flush_cleared: pend=%0d busy=%b expected 1/00", pend_cnt, rd_busy);
    end
    vecs++;
    set_rd(0, 6); #1;
    if (rd_busy[0] !== 1'b1 || sb_err !== m_err) begin
      fails++; $display("FAIL flush_survive: busy=%b err=%b expected 1/%b", rd_busy[0], sb_err, m_err);
    end
    vecs++;
  endtask

  function automatic int rnd_reg();
    // Bias toward a few registers so collisions happen often.
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG-1)) : int'($urandom_range(0, 5));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int j = 0; j < NFWD; j++)
        set_fwd(j, $urandom_range(0, 3) == 0, rnd_reg(), $urandom());
      for (int p = 0; p < NRD; p++) set_rd(p, rnd_reg());
      if ($urandom_range(0, 1) == 1) write(rnd_reg(), $urandom(), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) sbset(rnd_reg());
      sb_flush = ($urandom_range(0, 19) == 0);
      dbg_addr = AW'(rnd_reg());
      #1;
      for (int p = 0; p < NRD; p++) begin
        if ({rd_busy[p], port_data(p)} !== exp_rd(p)) begin
          fails++; $display("FAIL rand_rd%0d @%0d: got %b/%h expected %b/%h", p, n,
                            rd_busy[p], port_data(p), exp_rd(p) >> XLEN, exp_rd(p) & {1'b0, {XLEN{1'b1}}});
        end
        vecs++;
      end
      if (dbg_data !== exp_dbg()) begin
        fails++; $display("FAIL rand_dbg @%0d: got %h expected %h", n, dbg_data, exp_dbg());
      end
      vecs++;
      if (int'(pend_cnt) != m_pend() || sb_err !== m_err) begin
        fails++; $display("FAIL rand_sb @%0d: pend=%0d err=%b expected %0d/%b", n, pend_cnt, sb_err, m_pend(), m_err);
      end
      vecs++;
      step();
    end
  endtask

  // ---------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_write_bypass();
    test_fwd_priority();
    test_load_use();
    test_collision();
    test_reset_midrun();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
